// File: rtl/axi4_lite_mst_pkg.sv
// Shared definitions for the AXI4-Lite master: response codes and FSM state encoding.
package axi4_lite_mst_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/axi4_lite_mst_if.sv
// AXI4-Lite bus bundle between the local master and a register-space slave.
interface axi4_lite_mst_if;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi4_lite_mst.sv
// AXI4-Lite master: turns single-word local commands into one outstanding AXI4-Lite
// transaction at a time, with a timeout that aborts transfers to a hung slave.
module axi4_lite_mst
  import axi4_lite_mst_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned TO_W        = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_wr_i,
  input  logic [31:0]     cmd_addr_i,
  input  logic [31:0]     cmd_wdata_i,
  output logic            rsp_valid_o,
  output logic [31:0]     rsp_rdata_o,
  output logic [1:0]      rsp_resp_o,
  output logic            rsp_timeout_o,
  output logic            busy_o,
  axi4_lite_mst_if.master axi
);

  localparam logic            TO_EN   = (TIMEOUT_CYC != 32'd0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 32'd1);

  state_e          state_q, state_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            bready_q, bready_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            busy_q, busy_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_resp_q, rsp_resp_d;
  logic            rsp_timeout_q, rsp_timeout_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  logic aw_hs_s, w_hs_s, in_flight_s, completion_s, expired_s, abort_s;

  assign aw_hs_s      = awvalid_q & axi.awready;
  assign w_hs_s       = wvalid_q & axi.wready;
  assign in_flight_s  = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                        (state_q == ST_RD_REQ) || (state_q == ST_RD_RESP);
  assign completion_s = ((state_q == ST_WR_RESP) && axi.bvalid && bready_q) ||
                        ((state_q == ST_RD_RESP) && axi.rvalid && rready_q);
  assign expired_s    = TO_EN && (to_cnt_q == TO_LAST);
  // A response landing in the expiry cycle takes priority over the abort.
  assign abort_s      = in_flight_s && expired_s && !completion_s;

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = 32'd0;
    rsp_resp_d    = RESP_OKAY;
    rsp_timeout_d = 1'b0;
    to_cnt_d      = in_flight_s ? (TO_EN ? to_cnt_q + TO_W'(1) : '0) : to_cnt_q;

    if (abort_s) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      state_d       = ST_DONE;
      rsp_valid_d   = 1'b1;
      rsp_resp_d    = RESP_SLVERR;
      rsp_timeout_d = 1'b1;
      to_cnt_d      = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i && cmd_ready_q) begin
            addr_d    = cmd_addr_i;
            wdata_d   = cmd_wdata_i;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            awvalid_d = cmd_wr_i;
            wvalid_d  = cmd_wr_i;
            arvalid_d = ~cmd_wr_i;
            to_cnt_d  = '0;
            state_d   = cmd_wr_i ? ST_WR_REQ : ST_RD_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WR_REQ: begin
          // AW and W retire independently; B is only opened once both have gone.
          if (aw_hs_s) begin
            awvalid_d = 1'b0;
            aw_done_d = 1'b1;
          end else begin
            awvalid_d = awvalid_q;
            aw_done_d = aw_done_q;
          end
          if (w_hs_s) begin
            wvalid_d = 1'b0;
            w_done_d = 1'b1;
          end else begin
            wvalid_d = wvalid_q;
            w_done_d = w_done_q;
          end
          if ((aw_done_q || aw_hs_s) && (w_done_q || w_hs_s)) begin
            bready_d = 1'b1;
            state_d  = ST_WR_RESP;
          end else begin
            state_d = ST_WR_REQ;
          end
        end
        ST_WR_RESP: begin
          if (completion_s) begin
            bready_d    = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_resp_d  = axi.bresp;
            state_d     = ST_DONE;
          end else begin
            state_d = ST_WR_RESP;
          end
        end
        ST_RD_REQ: begin
          if (arvalid_q && axi.arready) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
            state_d   = ST_RD_RESP;
          end else begin
            state_d = ST_RD_REQ;
          end
        end
        ST_RD_RESP: begin
          if (completion_s) begin
            rready_d    = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = axi.rdata;
            rsp_resp_d  = axi.rresp;
            state_d     = ST_DONE;
          end else begin
            state_d = ST_RD_RESP;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          bready_d  = 1'b0;
          arvalid_d = 1'b0;
          rready_d  = 1'b0;
          state_d   = ST_IDLE;
        end
      endcase
    end

    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      addr_q        <= 32'd0;
      wdata_q       <= 32'd0;
      cmd_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'd0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  assign axi.awvalid   = awvalid_q;
  assign axi.awaddr    = addr_q;
  assign axi.wvalid    = wvalid_q;
  assign axi.wdata     = wdata_q;
  assign axi.bready    = bready_q;
  assign axi.arvalid   = arvalid_q;
  assign axi.araddr    = addr_q;
  assign axi.rready    = rready_q;
  assign cmd_ready_o   = cmd_ready_q;
  assign busy_o        = busy_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_resp_o    = rsp_resp_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_axi4_lite_mst.sv
// Self-checking bench for axi4_lite_mst: vector table plus scoreboard, with a delay-programmable slave.
module tb_axi4_lite_mst;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_wr = 1'b0;
  logic [31:0] cmd_addr = 32'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic        busy;

  always #5 clk = ~clk;

  axi4_lite_mst_if axi();

  axi4_lite_mst #(.TIMEOUT_CYC(16), .TO_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_wr_i(cmd_wr),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_resp_o(rsp_resp),
    .rsp_timeout_o(rsp_timeout), .busy_o(busy), .axi(axi)
  );

  // Slave model configuration and state
  int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_r_dly = 0;
  bit          cfg_ar_never = 1'b0;
  logic [1:0]  cfg_resp = 2'b00;
  logic [31:0] cfg_rdata = 32'd0;
  logic        s_awready = 1'b0, s_wready = 1'b0, s_arready = 1'b0, b_m = 1'b0, r_m = 1'b0;
  logic        stray_b = 1'b0;
  int          aw_n = 0, w_n = 0, b_n = 0, r_n = 0;

  assign axi.awready = s_awready;
  assign axi.wready  = s_wready;
  assign axi.bvalid  = b_m | stray_b;
  assign axi.bresp   = cfg_resp;
  assign axi.arready = s_arready;
  assign axi.rvalid  = r_m;
  assign axi.rdata   = r_m ? cfg_rdata : 32'd0;
  assign axi.rresp   = cfg_resp;

  initial begin
    forever begin
      @(negedge clk);
      if (!axi.awvalid) begin s_awready = 1'b0; aw_n = 0; end
      else if (aw_n >= cfg_aw_dly) s_awready = 1'b1;
      else aw_n++;
      if (!axi.wvalid) begin s_wready = 1'b0; w_n = 0; end
      else if (w_n >= cfg_w_dly) s_wready = 1'b1;
      else w_n++;
      if (!axi.bready) begin b_m = 1'b0; b_n = 0; end
      else if (b_n >= cfg_b_dly) b_m = 1'b1;
      else b_n++;
      s_arready = axi.arvalid && !cfg_ar_never;
      if (!axi.rready) begin r_m = 1'b0; r_n = 0; end
      else if (r_n >= cfg_r_dly) r_m = 1'b1;
      else r_n++;
    end
  end

  // Cycle counter, valid-cycle counts and handshake captures
  int          cyc = 0, n_aw = 0, n_w = 0, n_ar = 0;
  logic [31:0] cap_aw = 32'd0, cap_w = 32'd0, cap_ar = 32'd0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (axi.awvalid) n_aw <= n_aw + 1;
    if (axi.wvalid)  n_w  <= n_w + 1;
    if (axi.arvalid) n_ar <= n_ar + 1;
    if (axi.awvalid && axi.awready) cap_aw <= axi.awaddr;
    if (axi.wvalid && axi.wready)   cap_w  <= axi.wdata;
    if (axi.arvalid && axi.arready) cap_ar <= axi.araddr;
  end

  int errors = 0, checks = 0, n_rsp = 0, ovl = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endfunction

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy && cmd_ready) ovl++;
      if (rsp_valid) begin
        n_rsp++;
        chk("busy_at_rsp", 64'(busy), 64'd1);
        if (sb_q.size() == 0) begin
          chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
          chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
          chk("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
        end
      end
    end
  end

  typedef struct {
    bit          wr;
    logic [31:0] addr, wdata;
    int          aw_dly, w_dly, b_dly, r_dly;
    bit          ar_never;
    logic [1:0]  slv_resp;
    logic [31:0] slv_rdata;
    logic [31:0] e_rdata;
    logic [1:0]  e_resp;
    bit          e_to;
    int          e_lat, e_aw, e_w, e_ar;
  } vec_t;

  task automatic issue(input vec_t v, input bit hold, output int acc, output bit ok);
    int k;
    cfg_aw_dly = v.aw_dly; cfg_w_dly = v.w_dly; cfg_b_dly = v.b_dly; cfg_r_dly = v.r_dly;
    cfg_ar_never = v.ar_never; cfg_resp = v.slv_resp; cfg_rdata = v.slv_rdata;
    cmd_valid = 1'b1; cmd_wr = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    ok = cmd_ready;
    acc = cyc;
    if (!ok) begin
      chk("accept_wait", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
    end else begin
      sb_q.push_back('{v.e_rdata, v.e_resp, v.e_to, cyc, v.e_lat});
      @(negedge clk);
      if (!hold) begin
        cmd_valid = 1'b0; cmd_wr = ~v.wr; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata;
      end
    end
  endtask

  task automatic wait_rsp(input int target);
    int k;
    k = 0;
    while (n_rsp < target && k < 100) begin @(negedge clk); k++; end
    if (n_rsp < target) chk("rsp_wait", 64'(n_rsp), 64'(target));
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int aw0, w0, ar0, r0, acc;
    bit ok;
    aw0 = n_aw; w0 = n_w; ar0 = n_ar; r0 = n_rsp;
    issue(v, 1'b0, acc, ok);
    if (ok) begin
      wait_rsp(r0 + 1);
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_rsp_count", idx), 64'(n_rsp), 64'(r0 + 1));
      chk($sformatf("v%0d_aw_cycles", idx), 64'(n_aw - aw0), 64'(v.e_aw));
      chk($sformatf("v%0d_w_cycles", idx), 64'(n_w - w0), 64'(v.e_w));
      chk($sformatf("v%0d_ar_cycles", idx), 64'(n_ar - ar0), 64'(v.e_ar));
      if (v.wr) begin
        chk($sformatf("v%0d_awaddr", idx), 64'(cap_aw), 64'(v.addr));
        chk($sformatf("v%0d_wdata", idx), 64'(cap_w), 64'(v.wdata));
      end else if (!v.ar_never) begin
        chk($sformatf("v%0d_araddr", idx), 64'(cap_ar), 64'(v.addr));
      end
    end
  endtask

  vec_t vecs[10];

  initial begin
    int acc_a, acc_b, r0;
    bit ok_a, ok_b;
    vec_t va, vb, vr;

    //          wr addr          wdata          aw w  b  r  arN resp   slv_rdata      e_rdata        e_resp to lat aw w ar
    vecs[0] = '{1'b1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0, 1'b0, 2'b00, 32'h0,         32'h0,         2'b00, 1'b0, 3,  1, 1, 0};
    vecs[1] = '{1'b1, 32'h20, 32'hA5A5_0001, 3, 0, 0, 0, 1'b0, 2'b00, 32'h0,         32'h0,         2'b00, 1'b0, 6,  4, 1, 0};
    vecs[2] = '{1'b1, 32'h24, 32'h1234_0024, 0, 2, 0, 0, 1'b0, 2'b01, 32'h0,         32'h0,         2'b01, 1'b0, 5,  1, 3, 0};
    vecs[3] = '{1'b0, 32'h04, 32'h0,         0, 0, 0, 5, 1'b0, 2'b10, 32'h1234_5678, 32'h1234_5678, 2'b10, 1'b0, 8,  0, 0, 1};
    vecs[4] = '{1'b0, 32'h08, 32'h0,         0, 0, 0, 0, 1'b0, 2'b11, 32'hCAFE_F00D, 32'hCAFE_F00D, 2'b11, 1'b0, 3,  0, 0, 1};
    vecs[5] = '{1'b0, 32'h0C, 32'h0,         0, 0, 0, 0, 1'b1, 2'b00, 32'h0,         32'h0,         2'b10, 1'b1, 17, 0, 0, 16};
    vecs[6] = '{1'b0, 32'h14, 32'h0,         0, 0, 0, 14, 1'b0, 2'b00, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 2'b00, 1'b0, 17, 0, 0, 1};
    vecs[7] = '{1'b0, 32'h18, 32'h0,         0, 0, 0, 15, 1'b0, 2'b00, 32'h1111_1111, 32'h0,         2'b10, 1'b1, 17, 0, 0, 1};
    vecs[8] = '{1'b1, 32'h1C, 32'h55AA_55AA, 0, 0, 20, 0, 1'b0, 2'b00, 32'h0,        32'h0,         2'b10, 1'b1, 17, 1, 1, 0};
    vecs[9] = '{1'b1, 32'h30, 32'h00C0_FFEE, 2, 2, 0, 0, 1'b0, 2'b00, 32'h0,         32'h0,         2'b00, 1'b0, 5,  3, 3, 0};

    repeat (2) @(negedge clk);
    chk("rst_ctl", 64'({cmd_ready, busy, rsp_valid, rsp_timeout, rsp_resp,
                        axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}), 64'd0);
    chk("rst_data", 64'(rsp_rdata | axi.awaddr | axi.wdata | axi.araddr), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'({cmd_ready, busy}), 64'b10);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Back-to-back with cmd_valid held: second accept one cycle after the first rsp_valid
    va = vecs[0]; va.addr = 32'h40; va.wdata = 32'h1111_2222;
    vb = vecs[4]; vb.addr = 32'h44; vb.slv_resp = 2'b00; vb.slv_rdata = 32'h3333_4444;
    vb.e_rdata = 32'h3333_4444; vb.e_resp = 2'b00;
    r0 = n_rsp;
    issue(va, 1'b1, acc_a, ok_a);
    issue(vb, 1'b0, acc_b, ok_b);
    chk("b2b_accept_gap", 64'(acc_b - acc_a), 64'd4);
    wait_rsp(r0 + 2);
    chk("b2b_b_araddr", 64'(cap_ar), 64'h44);

    // Stray bvalid while idle must not produce a response
    repeat (2) @(negedge clk);
    r0 = n_rsp;
    stray_b = 1'b1;
    repeat (5) @(negedge clk);
    stray_b = 1'b0;
    repeat (5) @(negedge clk);
    chk("stray_b_no_rsp", 64'(n_rsp), 64'(r0));
    chk("stray_b_idle", 64'({cmd_ready, busy, axi.bready}), 64'b100);

    // Asynchronous reset while waiting in WR_RESP
    vr = vecs[8]; vr.addr = 32'h50; vr.wdata = 32'h7777_8888; vr.b_dly = 30;
    r0 = n_rsp;
    issue(vr, 1'b0, acc_a, ok_a);
    for (int k = 0; k < 20 && !axi.bready; k++) @(negedge clk);
    chk("rst_mid_bready", 64'(axi.bready), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ctl", 64'({cmd_ready, busy, rsp_valid, rsp_timeout, rsp_resp,
                            axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}), 64'd0);
    chk("rst_mid_data", 64'(rsp_rdata | axi.awaddr | axi.wdata | axi.araddr), 64'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("rst_mid_no_rsp", 64'(n_rsp), 64'(r0));
    chk("rst_mid_ready", 64'({cmd_ready, busy}), 64'b10);

    chk("ready_busy_exclusive", 64'(ovl), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
